// File: rtl/handshake_pkg.sv
// ---------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the 4-phase req/ack clock-domain-crossing handshake.
// Holds the state encoding used by the sender FSM and the default parameter
// values so that the sender and a matching receiver agree on them.
// No ports (package).
// ---------------------------------------------------------------------------
package handshake_pkg;

   // Handshake phases: idle, request raised and waiting for ack high,
   // request released and waiting for ack low.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2
   } state_t;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/handshake_sender_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Multi-flop synchroniser for a single asynchronous level. Every stage resets
// to 0. The receiving side of the handshake reuses this block for its req
// input.
// Ports:
//   clk      in   sampling clock
//   g_reset  in   synchronous active-low reset
//   d        in   asynchronous input level
//   q        out  synchronised level (last stage of the chain)
// ---------------------------------------------------------------------------
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic g_reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // The raw input enters bit 0 and moves one stage towards the output on
   // every clock, giving metastability STAGES-1 cycles to resolve.
   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   // All stages clear on reset so a stale far-side level cannot leak through.
   always_ff @(posedge clk) begin
      if (!g_reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/handshake_sender.sv
// ---------------------------------------------------------------------------
// handshake_sender
// Transmit side of a 4-phase req/ack CDC handshake. A one-cycle send pulse
// captures a word and raises req_o; the synchronised ack releases req_o and,
// once ack falls again, the transfer completes with a done pulse. A per-phase
// timer raises a sticky timeout flag but never aborts the handshake.
// Ports:
//   clk      in   single clock, rising edge
//   g_reset  in   synchronous active-low reset
//   send     in   one-cycle transfer request
//   data_in  in   word captured when send is accepted
//   ack_i    in   asynchronous acknowledge from the far domain
//   req_o    out  registered request level
//   data_o   out  registered word, stable while busy
//   busy     out  handshake in progress
//   done     out  one-cycle pulse at completion
//   overrun  out  one-cycle pulse when a send is dropped
//   timeout  out  sticky phase-timeout flag
// ---------------------------------------------------------------------------
module handshake_sender
   import handshake_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              g_reset,
   input  logic              send,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ack_i,
   output logic              req_o,
   output logic [DATA_W-1:0] data_o,
   output logic              busy,
   output logic              done,
   output logic              overrun,
   output logic              timeout
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC);

   logic              ack_s;
   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic              timeout_q, timeout_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [TIMER_W-1:0] timer_q, timer_d;

   // Bring the far-domain acknowledge into this clock domain.
   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk     (clk),
      .g_reset (g_reset),
      .d       (ack_i),
      .q       (ack_s)
   );

   // Next-state logic. A send is only taken in IDLE with ack_s low; in any
   // other situation it is dropped and flagged as overrun. The timer restarts
   // on every phase change so the timeout measures a single phase, and it
   // saturates so the flag stays meaningful for arbitrarily long stalls.
   // req and busy are computed from the next state so that the registered
   // outputs line up with the state register and never glitch.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      timer_d   = timer_q;
      timeout_d = timeout_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (send) begin
               if (!ack_s) begin
                  state_d   = REQ_HI;
                  data_d    = data_in;
                  timeout_d = 1'b0;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
         REQ_HI: begin
            overrun_d = send;
            if (ack_s) begin
               state_d = REQ_LO;
            end
         end
         REQ_LO: begin
            overrun_d = send;
            if (!ack_s) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != state_q) begin
         timer_d = '0;
      end else if (state_q != IDLE) begin
         if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TIMER_W'(1);
         end
         if (timer_d == TIMER_MAX) begin
            timeout_d = 1'b1;
         end
      end

      req_d  = (state_d == REQ_HI);
      busy_d = (state_d != IDLE);
   end

   // Single register bank for the FSM and all outputs. Reset mid-handshake
   // drops req at this edge and suppresses any done pulse.
   always_ff @(posedge clk) begin
      if (!g_reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         data_q    <= '0;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         data_q    <= data_d;
         timer_q   <= timer_d;
      end
   end

   assign req_o   = req_q;
   assign data_o  = data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = overrun_q;
   assign timeout = timeout_q;

endmodule
